bch_synd_t3_serial: RTL and testbench



---
 rtl/bch_synd_t3_serial.sv | 132 +++++++++++++
 tb/tb_bch_synd_t3_serial.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_synd_t3_serial.sv
// Bit-serial odd-syndrome calculator (S1, S3, S5) for the t=3 binary BCH code over GF(2^10).
// Horner accumulation, MSB-first; results are registered, held, and flagged with a one-cycle strobe.
module bch_synd_t3_serial #(
  parameter int GF_LEN = 10,
  parameter int CW_LEN = 1023,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_start,
  input  logic              in_bit,
  output logic              busy,
  output logic              synd_valid,
  output logic [GF_LEN-1:0] synd1,
  output logic [GF_LEN-1:0] synd3,
  output logic [GF_LEN-1:0] synd5,
  output logic              err_free
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  // Low-order terms of x^10 = x^3 + 1
  localparam logic [GF_LEN-1:0] POLY_LOW = GF_LEN'('h009);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CW_LEN);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GF_LEN-1:0]   acc1_q, acc1_d;
  logic [GF_LEN-1:0]   acc3_q, acc3_d;
  logic [GF_LEN-1:0]   acc5_q, acc5_d;
  logic [GF_LEN-1:0]   synd1_q, synd1_d;
  logic [GF_LEN-1:0]   synd3_q, synd3_d;
  logic [GF_LEN-1:0]   synd5_q, synd5_d;
  logic                err_free_q, err_free_d;
  logic                synd_valid_q, synd_valid_d;

  logic                start_bit;
  logic                accept_bit;
  logic [GF_LEN-1:0]   bit_ext;

  function automatic logic [GF_LEN-1:0] mul_alpha(input logic [GF_LEN-1:0] a);
    mul_alpha = {a[GF_LEN-2:0], 1'b0} ^ ({GF_LEN{a[GF_LEN-1]}} & POLY_LOW);
  endfunction

  // Constant-power multiply; unrolls to a fixed XOR network
  function automatic logic [GF_LEN-1:0] mul_alpha_pow(input logic [GF_LEN-1:0] a,
                                                      input int unsigned     n);
    logic [GF_LEN-1:0] r;
    r = a;
    for (int unsigned i = 0; i < n; i++) begin
      r = mul_alpha(r);
    end
    mul_alpha_pow = r;
  endfunction

  assign start_bit  = in_valid & in_start;
  assign accept_bit = in_valid & (in_start | (state_q == ACCUM));
  assign bit_ext    = {{(GF_LEN-1){1'b0}}, in_bit};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc1_d       = acc1_q;
    acc3_d       = acc3_q;
    acc5_d       = acc5_q;
    synd1_d      = synd1_q;
    synd3_d      = synd3_q;
    synd5_d      = synd5_q;
    err_free_d   = err_free_q;
    synd_valid_d = 1'b0;

    if (start_bit) begin
      // A start bit always begins a fresh word, aborting any word in progress
      state_d = ACCUM;
      cnt_d   = CNT_W'(1);
      acc1_d  = bit_ext;
      acc3_d  = bit_ext;
      acc5_d  = bit_ext;
    end else if (accept_bit) begin
      cnt_d  = cnt_q + 1'b1;
      acc1_d = mul_alpha_pow(acc1_q, 1) ^ bit_ext;
      acc3_d = mul_alpha_pow(acc3_q, 3) ^ bit_ext;
      acc5_d = mul_alpha_pow(acc5_q, 5) ^ bit_ext;
      if (cnt_d == LAST_CNT) begin
        state_d      = IDLE;
        synd1_d      = acc1_d;
        synd3_d      = acc3_d;
        synd5_d      = acc5_d;
        err_free_d   = ((acc1_d | acc3_d | acc5_d) == '0);
        synd_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc1_q       <= '0;
      acc3_q       <= '0;
      acc5_q       <= '0;
      synd1_q      <= '0;
      synd3_q      <= '0;
      synd5_q      <= '0;
      err_free_q   <= 1'b0;
      synd_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc1_q       <= acc1_d;
      acc3_q       <= acc3_d;
      acc5_q       <= acc5_d;
      synd1_q      <= synd1_d;
      synd3_q      <= synd3_d;
      synd5_q      <= synd5_d;
      err_free_q   <= err_free_d;
      synd_valid_q <= synd_valid_d;
    end
  end

  assign busy       = (state_q == ACCUM);
  assign synd_valid = synd_valid_q;
  assign synd1      = synd1_q;
  assign synd3      = synd3_q;
  assign synd5      = synd5_q;
  assign err_free   = err_free_q;

endmodule

// File: tb/tb_bch_synd_t3_serial.sv
// Scoreboard bench for bch_synd_t3_serial: words are driven MSB-first, expected syndromes
// are queued on the last bit and matched against each synd_valid pulse.
module tb_bch_synd_t3_serial;

  localparam int N = 1023;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_start;
  logic       in_bit;
  logic       busy;
  logic       synd_valid;
  logic [9:0] synd1;
  logic [9:0] synd3;
  logic [9:0] synd5;
  logic       err_free;

  bch_synd_t3_serial #(
    .GF_LEN(10),
    .CW_LEN(N),
    .CNT_W (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .in_bit    (in_bit),
    .busy      (busy),
    .synd_valid(synd_valid),
    .synd1     (synd1),
    .synd3     (synd3),
    .synd5     (synd5),
    .err_free  (err_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] s1;
    logic [9:0] s3;
    logic [9:0] s5;
    logic       ef;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp   = 0;
  int         n_err   = 0;
  int         cyc     = 0;
  int         n_pulse = 0;
  int         n_push  = 0;
  logic [9:0] hold1   = '0;
  logic [9:0] hold3   = '0;
  logic [9:0] hold5   = '0;
  logic       holdef  = 1'b0;
  logic [9:0] pw[0:N-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] mulx(input logic [9:0] a);
    logic [9:0] m;
    m = {a[8:0], 1'b0};
    if (a[9]) m = m ^ 10'h009;
    return m;
  endfunction

  task automatic synd_model(input logic [N-1:0] w, output logic [9:0] a, output logic [9:0] b,
                            output logic [9:0] c);
    a = '0; b = '0; c = '0;
    for (int d = 0; d < N; d++) begin
      if (w[d]) begin
        a = a ^ pw[d % N];
        b = b ^ pw[(3 * d) % N];
        c = c ^ pw[(5 * d) % N];
      end
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation, one cycle after its last bit
  always @(negedge clk) begin
    exp_t e;
    if (synd_valid === 1'b1) begin
      n_pulse++;
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", 32'(synd_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("synd1", 32'(synd1), 32'(e.s1));
        check_eq("synd3", 32'(synd3), 32'(e.s3));
        check_eq("synd5", 32'(synd5), 32'(e.s5));
        check_eq("err_free", 32'(err_free), 32'(e.ef));
        check_eq("latency_cycle", 32'(cyc), 32'(e.cyc));
        check_eq("busy_at_valid", 32'(busy), 32'd0);
        hold1  = e.s1;
        hold3  = e.s3;
        hold5  = e.s5;
        holdef = e.ef;
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic b);
    @(negedge clk);
    in_valid = v;
    in_start = s;
    in_bit   = b;
  endtask

  task automatic send_word(input logic [N-1:0] w, input int nbits, input bit gaps,
                           input bit hold_chk, input bit push,
                           input logic [9:0] e1, input logic [9:0] e3, input logic [9:0] e5);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      if (gaps && i > 0) begin
        while ($urandom_range(0, 3) == 0) begin
          drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          if (hold_chk && i > 3) begin
            #2;
            check_eq("hold_s1", 32'(synd1), 32'(hold1));
            check_eq("hold_s5", 32'(synd5), 32'(hold5));
            check_eq("hold_ef", 32'(err_free), 32'(holdef));
            check_eq("busy_stall", 32'(busy), 32'd1);
          end
        end
      end
      drive(1'b1, (i == 0), w[N-1-i]);
      if (i == 10) check_eq("busy_midword", 32'(busy), 32'd1);
      if (push && i == N - 1) begin
        e.s1  = e1;
        e.s3  = e3;
        e.s5  = e5;
        e.ef  = ((e1 | e3 | e5) == 10'h000);
        e.cyc = cyc + 1;
        sb.push_back(e);
        n_push++;
      end
    end
  endtask

  initial begin
    logic [N-1:0] w;
    logic [9:0]   m1, m3, m5;

    pw[0] = 10'h001;
    for (int i = 1; i < N; i++) pw[i] = mulx(pw[i-1]);

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_bit   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_synd1", 32'(synd1), 32'd0);
    check_eq("rst_synd3", 32'(synd3), 32'd0);
    check_eq("rst_synd5", 32'(synd5), 32'd0);
    check_eq("rst_err_free", 32'(err_free), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(synd_valid), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // Fixed-pattern words
    w = '0;
    send_word(w, N, 1'b0, 1'b0, 1'b1, 10'h000, 10'h000, 10'h000);
    drive(1'b0, 1'b0, 1'b0);
    w = '0; w[0] = 1'b1;
    send_word(w, N, 1'b0, 1'b0, 1'b1, 10'h001, 10'h001, 10'h001);
    drive(1'b0, 1'b0, 1'b0);
    w = '0; w[1] = 1'b1;
    send_word(w, N, 1'b0, 1'b0, 1'b1, 10'h002, 10'h008, 10'h020);
    drive(1'b0, 1'b0, 1'b0);
    w = '0; w[9] = 1'b1;
    send_word(w, N, 1'b0, 1'b0, 1'b1, 10'h200, 10'h0C8, 10'h0A9);

    // Back-to-back: degree-1 word, then degree-0 word with random stalls
    w = '0; w[1] = 1'b1;
    send_word(w, N, 1'b0, 1'b0, 1'b1, 10'h002, 10'h008, 10'h020);
    w = '0; w[0] = 1'b1;
    send_word(w, N, 1'b1, 1'b1, 1'b1, 10'h001, 10'h001, 10'h001);
    drive(1'b0, 1'b0, 1'b0);

    // Random word against the power-table model
    for (int i = 0; i < N; i++) w[i] = 1'($urandom_range(0, 1));
    synd_model(w, m1, m3, m5);
    send_word(w, N, 1'b1, 1'b0, 1'b1, m1, m3, m5);
    drive(1'b0, 1'b0, 1'b0);

    // Stray bits in IDLE must not start a word
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      if (i > 0) check_eq("idle_stray_busy", 32'(busy), 32'd0);
    end

    // Abort after 500 bits, then a full zero word
    for (int i = 0; i < N; i++) w[i] = 1'($urandom_range(0, 1));
    send_word(w, 500, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 10'h000);
    w = '0;
    send_word(w, N, 1'b0, 1'b0, 1'b1, 10'h000, 10'h000, 10'h000);
    drive(1'b0, 1'b0, 1'b0);

    // Nonzero held outputs, then reset in the middle of the next word
    w = '0; w[9] = 1'b1;
    send_word(w, N, 1'b0, 1'b0, 1'b1, 10'h200, 10'h0C8, 10'h0A9);
    for (int i = 0; i < N; i++) w[i] = 1'($urandom_range(0, 1));
    send_word(w, 300, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 10'h000);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_synd1", 32'(synd1), 32'd0);
    check_eq("midrst_synd3", 32'(synd3), 32'd0);
    check_eq("midrst_synd5", 32'(synd5), 32'd0);
    check_eq("midrst_err_free", 32'(err_free), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      check_eq("postrst_busy", 32'(busy), 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    check_eq("sb_pending", 32'(sb.size()), 32'd0);
    check_eq("pulse_count", 32'(n_pulse), 32'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
